sb_timer_bridge: RTL and testbench
==================================

SB_TIMER_BRIDGE -- requirements
Module: sb_timer_bridge

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sb_WriteEnable  input  1  write strobe from the data-memory side of the system bridge.
REQ-005 sb_ReadEnable  input  1  bridge select / read request.
REQ-006 sb_Address  input  32  byte address; decoded window 0x7F00-0x7F1F.
REQ-007 sb_DataIn  input  32  write data.
REQ-008 sb_DataOut  output  32  combinational read data.
REQ-009 sb_exception  output  1  combinational access fault.
REQ-010 irq  output  2  per-timer interrupt request; bit0 = timer0, bit1 = timer1.

Function
REQ-011 SHALL place timer0 at base 0x7F00 and timer1 at base 0x7F10; sb_Address[4] selects the timer.
REQ-012 Per-timer offsets SHALL be: 0x0 CTRL (bit3 IM, bits2:1 Mode, bit0 Enable; bits31:4 read 0), 0x4 PRESET (rw), 0x8 COUNT (read-only), 0xC reserved (reads 0).
REQ-013 sb_DataOut SHALL be the selected register in the same cycle (zero latency); 0 when sb_ReadEnable is low.
REQ-014 sb_exception SHALL be 1 when sb_ReadEnable=1 and any of: address outside the window, sb_Address[1:0]!=0, or sb_WriteEnable=1 to COUNT or 0xC.
REQ-015 Faulting writes SHALL be discarded; valid writes SHALL update the register at the next rising clk.
REQ-016 Each timer SHALL implement states IDLE, LOAD, CNT, INT.
REQ-017 IDLE: Enable=1 -> LOAD next cycle.
REQ-018 LOAD: COUNT<=PRESET; -> CNT.
REQ-019 CNT: Enable=0 -> IDLE; else COUNT>1 -> COUNT-1, stay; COUNT<=1 -> COUNT<=0, -> INT.
REQ-020 INT, Mode 0 (and reserved Modes 2,3): clear Enable, set pending, -> IDLE.
REQ-021 INT, Mode 1: set pending for exactly one cycle, -> LOAD (auto-reload), Enable kept.
REQ-022 pending SHALL clear on any valid write to that timer's CTRL or PRESET; irq[n] = pending & IM.
REQ-023 A CTRL write in the same cycle as an internal Enable clear (INT) SHALL win; a write with Enable=0 during CNT SHALL force IDLE next cycle, COUNT frozen.
REQ-024 A PRESET write during CNT SHALL NOT alter the running COUNT; it applies at the next LOAD.
REQ-025 PRESET=0 SHALL pass LOAD -> CNT -> INT (period 3 cycles from Enable).

Reset
REQ-026 reset SHALL clear CTRL, PRESET, COUNT, pending to 0, state to IDLE, irq to 0; reset mid-count SHALL abort counting with no irq.
REQ-027 sb_DataOut and sb_exception SHALL remain combinational and reflect reset register values.

Configuration
REQ-028 With SB_TIMER_IRQ_EN defined: IM writable, irq driven per REQ-022.
REQ-029 Without SB_TIMER_IRQ_EN: IM reads 0, writes to it ignored, irq tied to 2'b00; counting and pending unchanged.

Structure
REQ-030 A shared package sb_pkg SHALL hold the state enum, register offsets, window bounds, timer bases, CTRL bit positions.
REQ-031 One sub-module sb_timer SHALL implement a single timer, instantiated twice; decode/read-mux/exception logic in sb_timer_bridge.

Verification
REQ-032 Write PRESET0=5, CTRL0=0x9 (IM, Mode0, En) -> COUNT 5,4,3,2,1,0; irq[0]=1 after INT, CTRL0 reads 0x8; write CTRL0=0 -> irq[0]=0.
REQ-033 Timer1 PRESET=3, CTRL=0xB (Mode1) -> irq[1] one-cycle pulse every 5 cycles, Enable stays 1.
REQ-034 Write to 0x7F08 or read 0x7F02 -> sb_exception=1, COUNT unchanged; read 0x7F20 -> sb_exception=1.
REQ-035 CTRL0=0 written while COUNT0=7 -> state IDLE, COUNT0 holds 6 (one decrement in flight), no irq.
REQ-036 reset asserted while COUNT1=2 -> all registers 0, irq=0, no INT afterwards.
REQ-037 Build without SB_TIMER_IRQ_EN, rerun REQ-032 -> irq stays 0, CTRL0 reads 0x0 after INT.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the system-bridge timer pair: FSM states, CTRL layout,
// register offsets and the decoded address window.
package sb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } timerState_e;

  // Field order mirrors the CTRL word: IM at bit 3, Mode at 2:1, Enable at 0.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrlReg_t;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_AUTO = 2'd1;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  localparam logic [31:0] WIN_LO      = 32'h0000_7F00;
  localparam logic [31:0] WIN_HI      = 32'h0000_7F1F;
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

  // The timer stride is a power of two, so a single address bit picks the timer.
  localparam int TIMER_SEL_BIT = $clog2(TIMER1_BASE - TIMER0_BASE);

  function automatic ctrlReg_t ctrlFromWord(input logic [31:0] w);
    ctrlReg_t c;
    c.im   = w[CTRL_IM_BIT];
    c.mode = w[CTRL_MODE_MSB:CTRL_MODE_LSB];
    c.en   = w[CTRL_EN_BIT];
    return c;
  endfunction

  function automatic logic [31:0] ctrlToWord(input ctrlReg_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_IM_BIT]                 = c.im;
    w[CTRL_MODE_MSB:CTRL_MODE_LSB] = c.mode;
    w[CTRL_EN_BIT]                 = c.en;
    return w;
  endfunction

endpackage

// File: rtl/sb_timer.sv
// One down-counting timer with one-shot / auto-reload modes and a pending flag.
// IM is writable only when SB_TIMER_IRQ_EN is defined; otherwise it stays 0.
module sb_timer
  import sb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrlWrite,
  input  logic        presetWrite,
  input  logic [31:0] writeData,
  output ctrlReg_t    ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        pending
);

  timerState_e state, nextState;
  ctrlReg_t    writeCtrl;

  always_comb begin
    writeCtrl = ctrlFromWord(writeData);
`ifdef SB_TIMER_IRQ_EN
`else
    writeCtrl.im = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: default assigned first so every path drives nextState and no latch is inferred.
    nextState = state;
    case (state)
      ST_IDLE: if (ctrl.en) nextState = ST_LOAD;
      ST_LOAD: nextState = ST_CNT;
      ST_CNT: begin
        if (!ctrl.en)               nextState = ST_IDLE;
        else if (count <= 32'd1)    nextState = ST_INT;
      end
      ST_INT:  nextState = (ctrl.mode == MODE_AUTO) ? ST_LOAD : ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= nextState;

      // A software CTRL write overrides the one-shot Enable clear in the same cycle.
      if (ctrlWrite)                                       ctrl    <= writeCtrl;
      else if (state == ST_INT && ctrl.mode != MODE_AUTO)  ctrl.en <= 1'b0;

      if (presetWrite) preset <= writeData;

      if (state == ST_LOAD)               count <= preset;
      else if (state == ST_CNT && ctrl.en) count <= (count > 32'd1) ? count - 32'd1 : '0;

      // In auto-reload the flag is raised by INT and dropped again by the following LOAD.
      if (ctrlWrite || presetWrite) pending <= 1'b0;
      else if (state == ST_INT)     pending <= 1'b1;
      else if (state == ST_LOAD)    pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sb_timer_bridge.sv
// Bus-facing wrapper: decodes the 0x7F00-0x7F1F window onto two sb_timer instances.
// irq is live only when SB_TIMER_IRQ_EN is defined (IM otherwise held at 0).
module sb_timer_bridge
  import sb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sb_WriteEnable,
  input  logic        sb_ReadEnable,
  input  logic [31:0] sb_Address,
  input  logic [31:0] sb_DataIn,
  output logic [31:0] sb_DataOut,
  output logic        sb_exception,
  output logic [1:0]  irq
);

  logic        inWindow, misaligned, readOnlyFault, validWrite, timerSel;
  logic [3:0]  regOffset;
  logic [1:0]  ctrlWrite, presetWrite, pending;
  ctrlReg_t    ctrl   [2];
  logic [31:0] preset [2];
  logic [31:0] count  [2];

  assign inWindow      = (sb_Address >= WIN_LO) && (sb_Address <= WIN_HI);
  assign misaligned    = |sb_Address[1:0];
  assign regOffset     = {sb_Address[3:2], 2'b00};
  assign timerSel      = sb_Address[TIMER_SEL_BIT];
  assign readOnlyFault = sb_WriteEnable && (regOffset == OFF_COUNT || regOffset == OFF_RSVD);
  assign sb_exception  = sb_ReadEnable && (!inWindow || misaligned || readOnlyFault);
  assign validWrite    = sb_ReadEnable && sb_WriteEnable && !sb_exception;

  for (genvar i = 0; i < 2; i++) begin : gTimer
    assign ctrlWrite[i]   = validWrite && (timerSel == 1'(i)) && (regOffset == OFF_CTRL);
    assign presetWrite[i] = validWrite && (timerSel == 1'(i)) && (regOffset == OFF_PRESET);
    // With IM held at 0 in the default build this reduces to a constant zero.
    assign irq[i]         = pending[i] & ctrl[i].im;

    sb_timer uTimer (
      .clk        (clk),
      .reset      (reset),
      .ctrlWrite  (ctrlWrite[i]),
      .presetWrite(presetWrite[i]),
      .writeData  (sb_DataIn),
      .ctrl       (ctrl[i]),
      .preset     (preset[i]),
      .count      (count[i]),
      .pending    (pending[i])
    );
  end

  always_comb begin
    sb_DataOut = '0;
    if (sb_ReadEnable && inWindow) begin
      case (regOffset)
        OFF_CTRL:   sb_DataOut = ctrlToWord(ctrl[timerSel]);
        OFF_PRESET: sb_DataOut = preset[timerSel];
        OFF_COUNT:  sb_DataOut = count[timerSel];
        default:    sb_DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_timer_bridge.sv
// Directed bench for sb_timer_bridge: register-access vector table followed by
// timer sequences; expectations follow SB_TIMER_IRQ_EN when it is defined.
module tb_sb_timer_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        sb_WriteEnable, sb_ReadEnable;
  logic [31:0] sb_Address, sb_DataIn, sb_DataOut;
  logic        sb_exception;
  logic [1:0]  irq;

  int nTests = 0;
  int nFail  = 0;

`ifdef SB_TIMER_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'hF;
  localparam logic        IRQ_ON    = 1'b1;
`else
  localparam logic [31:0] CTRL_MASK = 32'h7;
  localparam logic        IRQ_ON    = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expData;
    logic        expExc;
  } vec_t;

  vec_t vecs [20];
  int   aCnt [9] = '{0, 0, 5, 4, 3, 2, 1, 0, 0};

  sb_timer_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .sb_WriteEnable(sb_WriteEnable),
    .sb_ReadEnable (sb_ReadEnable),
    .sb_Address    (sb_Address),
    .sb_DataIn     (sb_DataIn),
    .sb_DataOut    (sb_DataOut),
    .sb_exception  (sb_exception),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] din);
    sb_WriteEnable = we;
    sb_ReadEnable  = re;
    sb_Address     = addr;
    sb_DataIn      = din;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic expExc,
                          input string name);
    drive(1'b1, 1'b1, addr, data);
    #1 check({name, ".exc"}, 32'(sb_exception), 32'(expExc));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [31:0] expData, input logic expExc,
                         input logic [1:0] expIrq, input string name);
    drive(1'b0, 1'b1, addr, '0);
    #1;
    check({name, ".data"}, sb_DataOut, expData);
    check({name, ".exc"}, 32'(sb_exception), 32'(expExc));
    check({name, ".irq"}, 32'(irq), 32'(expIrq));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h7F00, 32'h0,         32'h0,    1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h7F04, 32'h0,         32'h0,    1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h7F18, 32'h0,         32'h0,    1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h7F04, 32'h1234,      32'h0,    1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h7F04, 32'h0,         32'h1234, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h7F08, 32'hFFFF,      32'h0,    1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h7F08, 32'h0,         32'h0,    1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h7F02, 32'h0,         32'h0,    1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h7F20, 32'h0,         32'h0,    1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h7F0C, 32'h55,        32'h0,    1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h7F0C, 32'h0,         32'h0,    1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h7F04, 32'h0,         32'h0,    1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h7F14, 32'hAB,        32'h0,    1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h7F14, 32'h0,         32'h0,    1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h7F05, 32'hBEEF,      32'h1234, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 32'h7F04, 32'h0,         32'h1234, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h7EFC, 32'h0,         32'h0,    1'b1};
    vecs[17] = '{1'b1, 1'b1, 32'h7F10, 32'hFFFF_FFF0, 32'h0,    1'b0};
    vecs[18] = '{1'b0, 1'b1, 32'h7F10, 32'h0,         32'h0,    1'b0};
    vecs[19] = '{1'b1, 1'b1, 32'h7F1C, 32'h0,         32'h0,    1'b1};

    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Register access and address faults with both timers idle.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din);
      #1;
      check($sformatf("vec%0d.data", i), sb_DataOut, vecs[i].expData);
      check($sformatf("vec%0d.exc", i), 32'(sb_exception), 32'(vecs[i].expExc));
      check($sformatf("vec%0d.irq", i), 32'(irq), 32'h0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, '0, '0);

    // One-shot timer0 countdown from 5.
    pulseReset();
    writeReg(32'h7F04, 32'd5, 1'b0, "A.wpreset");
    writeReg(32'h7F00, 32'h9, 1'b0, "A.wctrl");
    for (int k = 0; k < 9; k++)
      readReg(32'h7F08, 32'(aCnt[k]), 1'b0, (k == 8) ? {1'b0, IRQ_ON} : 2'b00,
              $sformatf("A.count%0d", k));
    readReg(32'h7F00, 32'h8 & CTRL_MASK, 1'b0, {1'b0, IRQ_ON}, "A.ctrlAfterInt");
    writeReg(32'h7F00, 32'h0, 1'b0, "A.wctrl0");
    readReg(32'h7F00, 32'h0, 1'b0, 2'b00, "A.irqCleared");

    // Auto-reload timer1: one-cycle irq pulse every 5 cycles, Enable held.
    pulseReset();
    writeReg(32'h7F14, 32'd3, 1'b0, "B.wpreset");
    writeReg(32'h7F10, 32'hB, 1'b0, "B.wctrl");
    for (int k = 0; k < 18; k++)
      readReg(32'h7F10, 32'hB & CTRL_MASK, 1'b0,
              {IRQ_ON && k >= 6 && (k - 6) % 5 == 0, 1'b0}, $sformatf("B.cycle%0d", k));

    // Stop mid-count, PRESET write while counting, faults leave COUNT alone.
    pulseReset();
    writeReg(32'h7F04, 32'd10, 1'b0, "D.wpreset");
    writeReg(32'h7F00, 32'h9, 1'b0, "D.wctrl");
    readReg(32'h7F08, 32'd0,  1'b0, 2'b00, "D.count0");
    readReg(32'h7F08, 32'd0,  1'b0, 2'b00, "D.count1");
    readReg(32'h7F08, 32'd10, 1'b0, 2'b00, "D.count2");
    writeReg(32'h7F04, 32'd50, 1'b0, "D.wpresetRunning");
    readReg(32'h7F08, 32'd8,  1'b0, 2'b00, "D.count4");
    writeReg(32'h7F00, 32'h0, 1'b0, "D.stopAt7");
    for (int k = 0; k < 8; k++)
      readReg(32'h7F08, 32'd6, 1'b0, 2'b00, $sformatf("D.frozen%0d", k));
    readReg(32'h7F00, 32'h0, 1'b0, 2'b00, "D.ctrlStopped");
    writeReg(32'h7F08, 32'hFFFF, 1'b1, "D.wcount");
    readReg(32'h7F08, 32'd6, 1'b0, 2'b00, "D.countAfterFault");
    readReg(32'h7F02, 32'h0, 1'b1, 2'b00, "D.misaligned");
    writeReg(32'h7F00, 32'h1, 1'b0, "D.restart");
    readReg(32'h7F08, 32'd6,  1'b0, 2'b00, "D.restartIdle");
    readReg(32'h7F08, 32'd6,  1'b0, 2'b00, "D.restartLoad");
    readReg(32'h7F08, 32'd50, 1'b0, 2'b00, "D.newPreset");

    // Reset while timer1 is at COUNT=2 aborts the count with no interrupt.
    pulseReset();
    writeReg(32'h7F14, 32'd4, 1'b0, "E.wpreset");
    writeReg(32'h7F10, 32'h9, 1'b0, "E.wctrl");
    readReg(32'h7F18, 32'd0, 1'b0, 2'b00, "E.count0");
    readReg(32'h7F18, 32'd0, 1'b0, 2'b00, "E.count1");
    readReg(32'h7F18, 32'd4, 1'b0, 2'b00, "E.count2");
    readReg(32'h7F18, 32'd3, 1'b0, 2'b00, "E.count3");
    readReg(32'h7F18, 32'd2, 1'b0, 2'b00, "E.count4");
    pulseReset();
    readReg(32'h7F14, 32'd0, 1'b0, 2'b00, "E.presetCleared");
    readReg(32'h7F10, 32'd0, 1'b0, 2'b00, "E.ctrlCleared");
    for (int k = 0; k < 8; k++)
      readReg(32'h7F18, 32'd0, 1'b0, 2'b00, $sformatf("E.after%0d", k));

    // PRESET=0 reaches INT in 3 cycles; a CTRL write during INT keeps Enable.
    pulseReset();
    writeReg(32'h7F00, 32'h9, 1'b0, "F.wctrl");
    for (int k = 0; k < 3; k++)
      readReg(32'h7F08, 32'd0, 1'b0, 2'b00, $sformatf("F.count%0d", k));
    writeReg(32'h7F00, 32'h9, 1'b0, "F.wctrlDuringInt");
    for (int k = 4; k < 8; k++)
      readReg(32'h7F00, 32'h9 & CTRL_MASK, 1'b0, 2'b00, $sformatf("F.ctrl%0d", k));
    readReg(32'h7F00, 32'h8 & CTRL_MASK, 1'b0, {1'b0, IRQ_ON}, "F.secondInt");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
